// File: rtl/matrix_scan_bank_if.sv
// matrix_scan_bank_if
//   Bus bundle between a frame source and the matrix_scan_bank row scanner.
//   Parameters NCOLS / NROWS must match the scanner instance.
//   Signals:
//     en         scan enable (source -> scanner)
//     load       1-cycle strobe capturing frame_in (source -> scanner)
//     frame_in   NCOLS*NROWS pixels, pixel (c,r) at bit c*NROWS+r
//     row_sel    one-hot active row strobe (scanner -> panel)
//     col_out    column bits of the active row (scanner -> panel)
//     row_idx    index of the row currently scanned
//     frame_done 1-cycle pulse on each wrap to row 0
//   Modports: master = frame source / testbench, slave = scanner.
interface matrix_scan_bank_if #(
  parameter int NCOLS = 5,
  parameter int NROWS = 7
);
  localparam int RowW = (NROWS > 1) ? $clog2(NROWS) : 1;

  logic                     en;
  logic                     load;
  logic [NCOLS*NROWS-1:0]   frame_in;
  logic [NROWS-1:0]         row_sel;
  logic [NCOLS-1:0]         col_out;
  logic [RowW-1:0]          row_idx;
  logic                     frame_done;

  modport master (
    output en, load, frame_in,
    input  row_sel, col_out, row_idx, frame_done
  );

  modport slave (
    input  en, load, frame_in,
    output row_sel, col_out, row_idx, frame_done
  );
endinterface

// File: rtl/matrix_scan_bank.sv
// matrix_scan_bank
//   Time-multiplexed row scanner for the dot-matrix panel. A full NCOLS x NROWS
//   frame is held in a double buffer (active + shadow); one row at a time is
//   driven out as a one-hot row strobe plus its column bits. New frames are
//   only promoted to the active buffer at the wrap to row 0, so the panel never
//   shows a torn frame.
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous, active-high, overrides every other input
//     bus    matrix_scan_bank_if.slave (en, load, frame_in in;
//            row_sel, col_out, row_idx, frame_done out, all registered)
//   Optional build macro: SCAN_BLANKING_EN
//     Defined   -> a BLANK state of BLANK_CYCLES cycles follows every row,
//                  including NROWS-1 -> 0; frame_done marks entry to row 0.
//     Undefined -> rows are back-to-back, BLANK_CYCLES is unused.
module matrix_scan_bank #(
  parameter int NCOLS        = 5,
  parameter int NROWS        = 7,
  parameter int DWELL        = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  matrix_scan_bank_if.slave  bus
);
  localparam int RowW   = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int DwellW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam int FrameW = NCOLS * NROWS;
  localparam bit ParamsOk = (NROWS >= 2) && (DWELL >= 1) && (BLANK_CYCLES >= 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } stateT;

  stateT              stateReg, stateNext;
  logic [RowW-1:0]    rowReg, rowNext;
  logic [DwellW-1:0]  dwellReg, dwellNext;
  logic [FrameW-1:0]  activeReg, activeNext;
  logic [FrameW-1:0]  shadowReg, shadowNext;
  logic               pendingReg, pendingNext;
  logic [NROWS-1:0]   rowSelReg, rowSelNext;
  logic [NCOLS-1:0]   colOutReg, colOutNext;
  logic               frameDoneReg, frameDoneNext;
  logic               wrap;          // this edge moves row NROWS-1 -> 0
  logic               lastRow;
  logic [RowW-1:0]    rowInc;
  logic [NCOLS-1:0]   colPick;       // column bits of rowNext in activeNext

`ifdef SCAN_BLANKING_EN
  localparam int BlankW = $clog2(BLANK_CYCLES + 1);
  logic [BlankW-1:0]  blankReg, blankNext;
`endif

  assign lastRow = (rowReg == RowW'(NROWS - 1));
  assign rowInc  = rowReg + RowW'(1);

  // Outputs come straight from registers: no input-to-output path.
  assign bus.row_sel    = rowSelReg;
  assign bus.col_out    = colOutReg;
  assign bus.row_idx    = rowReg;
  assign bus.frame_done = frameDoneReg;

  // ---------------------------------------------------------------------------
  // State register (also registers the buffers and output values)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      rowReg       <= '0;
      dwellReg     <= '0;
      activeReg    <= '0;
      shadowReg    <= '0;
      pendingReg   <= 1'b0;
      rowSelReg    <= '0;
      colOutReg    <= '0;
      frameDoneReg <= 1'b0;
`ifdef SCAN_BLANKING_EN
      blankReg     <= '0;
`endif
    end else begin
      stateReg     <= stateNext;
      rowReg       <= rowNext;
      dwellReg     <= dwellNext;
      activeReg    <= activeNext;
      shadowReg    <= shadowNext;
      pendingReg   <= pendingNext;
      rowSelReg    <= rowSelNext;
      colOutReg    <= colOutNext;
      frameDoneReg <= frameDoneNext;
`ifdef SCAN_BLANKING_EN
      blankReg     <= blankNext;
`endif
    end
  end

  // Parameter legality guard; has no hardware cost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (ParamsOk);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: scan position and frame buffers
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    rowNext   = rowReg;
    dwellNext = dwellReg;
    wrap      = 1'b0;
`ifdef SCAN_BLANKING_EN
    blankNext = blankReg;
`endif

    if (!bus.en) begin
      stateNext = IDLE;
      rowNext   = '0;
      dwellNext = '0;
`ifdef SCAN_BLANKING_EN
      blankNext = '0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          stateNext = SHOW;
          rowNext   = '0;
          dwellNext = '0;
        end
        SHOW: begin
          if (dwellReg == DwellW'(DWELL - 1)) begin
            dwellNext = '0;
`ifdef SCAN_BLANKING_EN
            // Row index holds through the blank; it advances on re-entry to SHOW.
            stateNext = BLANK;
            blankNext = '0;
`else
            if (lastRow) begin
              rowNext = '0;
              wrap    = 1'b1;
            end else begin
              rowNext = rowInc;
            end
`endif
          end else begin
            dwellNext = dwellReg + DwellW'(1);
          end
        end
`ifdef SCAN_BLANKING_EN
        BLANK: begin
          if (blankReg == BlankW'(BLANK_CYCLES - 1)) begin
            stateNext = SHOW;
            blankNext = '0;
            dwellNext = '0;
            if (lastRow) begin
              rowNext = '0;
              wrap    = 1'b1;
            end else begin
              rowNext = rowInc;
            end
          end else begin
            blankNext = blankReg + BlankW'(1);
          end
        end
`endif
        default: begin
          stateNext = IDLE;
          rowNext   = '0;
          dwellNext = '0;
        end
      endcase
    end

    // Double buffer: a pending shadow frame is promoted only at the wrap.
    activeNext  = activeReg;
    shadowNext  = shadowReg;
    pendingNext = pendingReg;
    if (wrap && pendingReg) begin
      activeNext  = shadowReg;
      pendingNext = 1'b0;
    end
    if (bus.load) begin
      shadowNext = bus.frame_in;
      // Nothing is on screen in IDLE, and at the wrap the new frame starts
      // from row 0 anyway, so both cases can write active without tearing.
      if (stateReg == IDLE || wrap) begin
        activeNext  = bus.frame_in;
        pendingNext = 1'b0;
      end else begin
        pendingNext = 1'b1;
      end
    end
  end

  // Pick each column's pixel for the row being shown after this edge.
  generate
    for (genvar gi = 0; gi < NCOLS; gi++) begin : gCol
      logic [NROWS-1:0] colPixels;
      assign colPixels   = activeNext[gi*NROWS +: NROWS];
      assign colPick[gi] = colPixels[rowNext];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output logic: values that the registers will hold after this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    rowSelNext    = '0;
    colOutNext    = '0;
    frameDoneNext = wrap;
    if (stateNext == SHOW) begin
      rowSelNext = {{(NROWS-1){1'b0}}, 1'b1} << rowNext;
      colOutNext = colPick;
    end
  end

endmodule
